// File: rtl/mem_wait_controller_if.sv
// CPU/RAM bus bundle for mem_wait_controller: load/store handshake plus RAM strobes.
// slave = the controller; master = the requester and RAM side.
interface mem_wait_controller_if #(
    parameter int width      = 16,
    parameter int addr_width = 8
);
    logic                  req;
    logic                  we;
    logic [addr_width-1:0] addr;
    logic [width-1:0]      wdata;
    logic                  ready;
    logic [width-1:0]      rdata;
    logic                  error;
    logic                  mem_en;
    logic                  mem_we;
    logic [addr_width-1:0] mem_addr;
    logic [width-1:0]      mem_wdata;
    logic [width-1:0]      mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output ready, rdata, error, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  ready, rdata, error, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_wait_controller.sv
// Single-outstanding memory access controller with a fixed RAM wait-state window.
// Optional read bypass of a repeated address is enabled by defining MEMCTRL_READ_BYPASS_EN.
module mem_wait_controller #(
    parameter int width       = 16,
    parameter int addr_width  = 8,
    parameter int mem_depth   = 1 << addr_width,
    parameter int wait_states = 2
) (
    input logic                 clk,
    input logic                 rst,
    mem_wait_controller_if.slave bus
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    // One extra bit so mem_depth == 2**addr_width cannot wrap the bound.
    localparam logic [addr_width:0] max_addr = (addr_width + 1)'(mem_depth - 1);
    localparam logic [3:0]          ws_init  = 4'(wait_states);

    logic [0:0] state;
    logic [3:0] cnt;
    logic       pend;
    logic       pend_err;
    logic       oor;
    logic       hit;
    logic       done;

    assign oor  = {1'b0, bus.addr} > max_addr;
    assign done = (state == ACCESS) && (cnt == 4'd0);

`ifdef MEMCTRL_READ_BYPASS_EN
    logic [addr_width-1:0] last_addr;
    logic                  last_valid;

    assign hit = last_valid && !bus.we && (bus.addr == last_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_valid <= 1'b0;
            last_addr  <= '0;
        end else if (done) begin
            if (bus.mem_we) begin
                last_valid <= 1'b0;
            end else begin
                last_valid <= 1'b1;
                last_addr  <= bus.mem_addr;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Error and bypass responses park in pend for one cycle so their latency
    // matches a zero-wait access; the held req is not re-accepted meanwhile.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            pend          <= 1'b0;
            pend_err      <= 1'b0;
            bus.ready     <= 1'b0;
            bus.error     <= 1'b0;
            bus.rdata     <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend) begin
                        pend      <= 1'b0;
                        bus.ready <= 1'b1;
                        bus.error <= pend_err;
                    end else if (bus.req) begin
                        if (oor || hit) begin
                            pend     <= 1'b1;
                            pend_err <= oor;
                        end else begin
                            state         <= ACCESS;
                            cnt           <= ws_init;
                            bus.mem_en    <= 1'b1;
                            bus.mem_we    <= bus.we;
                            bus.mem_addr  <= bus.addr;
                            bus.mem_wdata <= bus.wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= IDLE;
                        bus.mem_en <= 1'b0;
                        bus.mem_we <= 1'b0;
                        bus.ready  <= 1'b1;
                        bus.error  <= 1'b0;
                        if (!bus.mem_we) bus.rdata <= bus.mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wait_controller.sv
// Randomized self-checking bench for mem_wait_controller against a transaction-level model.
// Build with or without MEMCTRL_READ_BYPASS_EN; the model follows the same macro.
module tb_mem_wait_controller;
    localparam int W     = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 200;
    localparam int WS    = 2;
`ifdef MEMCTRL_READ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic preload;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_wait_controller_if #(.width(W), .addr_width(AW)) bus ();

    mem_wait_controller #(
        .width(W), .addr_width(AW), .mem_depth(DEPTH), .wait_states(WS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Environment RAM, written only by this process.
    logic [W-1:0] seed_mem [256];
    logic [W-1:0] ram      [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= seed_mem[i];
        end else if (bus.mem_en && bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = ram[bus.mem_addr];

    // Transaction-level model state.
    logic [W-1:0]  ref_mem [256];
    logic [W-1:0]  exp_rdata;
    logic          exp_err;
    bit            bv_valid;
    logic [AW-1:0] bv_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where ready was seen
    // (keep=1) or one cycle later after dropping req (keep=0).
    task automatic xact(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d, input bit keep);
        bit oor, hit, got, bad;
        int lat, en_exp, n, en;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        oor    = (int'(a) >= DEPTH);
        hit    = BYP && bv_valid && !w && (a == bv_addr) && !oor;
        lat    = (oor || hit) ? 1 : WS + 1;
        en_exp = (oor || hit) ? 0 : WS + 1;
        n = 0; en = 0; got = 0; bad = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (bus.mem_en) begin
                en++;
                if (bus.mem_addr !== a || bus.mem_we !== w || (w && bus.mem_wdata !== d)) bad = 1;
            end
            if (bus.ready) begin
                got = 1;
                break;
            end
        end
        if (!oor) begin
            if (w) begin
                ref_mem[a] = d;
                bv_valid   = 0;
            end else if (!hit) begin
                exp_rdata = ref_mem[a];
                bv_valid  = 1;
                bv_addr   = a;
            end
        end
        exp_err = oor;
        chk("ready_seen", 32'(got), 32'd1);
        chk("latency", 32'(n - 1), 32'(lat));
        chk("mem_en_cycles", 32'(en), 32'(en_exp));
        chk("mem_bus_fields", 32'(bad), 32'd0);
        chk("error", 32'(bus.error), 32'(exp_err));
        chk("rdata", 32'(bus.rdata), 32'(exp_rdata));
        if (!keep) begin
            bus.req = 1'b0;
            @(negedge clk);
            chk("ready_one_cycle", 32'(bus.ready), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            seed_mem[i] = W'($urandom);
            ref_mem[i]  = seed_mem[i];
        end
        seed_mem[5] = 16'hBEEF;
        ref_mem[5]  = 16'hBEEF;
        exp_rdata = '0;
        exp_err   = 1'b0;
        bv_valid  = 0;
        bv_addr   = '0;

        // Reset held two cycles with a live request.
        rst = 1'b1; preload = 1'b1;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 8'd5; bus.wdata = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            preload = 1'b0;
            chk("rst_ready", 32'(bus.ready), 32'd0);
            chk("rst_error", 32'(bus.error), 32'd0);
            chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
            chk("rst_rdata", 32'(bus.rdata), 32'd0);
        end
        rst = 1'b0; bus.req = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_en", 32'(bus.mem_en), 32'd0);

        xact(1'b0, 8'd5, '0, 0);
        chk("read5_beef", 32'(bus.rdata), 32'hBEEF);
        xact(1'b1, 8'd7, 16'h1234, 0);
        chk("write7_wdata_hold", 32'(bus.mem_wdata), 32'h1234);
        chk("write7_rdata_keep", 32'(bus.rdata), 32'hBEEF);
        xact(1'b0, 8'd200, '0, 0);
        xact(1'b0, 8'd199, '0, 0);
        xact(1'b0, 8'd3, '0, 1);
        xact(1'b0, 8'd4, '0, 0);
        xact(1'b0, 8'd9, '0, 0);
        xact(1'b0, 8'd9, '0, 0);
        xact(1'b1, 8'd9, 16'hABCD, 0);
        xact(1'b0, 8'd9, '0, 0);
        xact(1'b0, 8'd7, '0, 0);

        // Abort in the second access cycle.
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 8'd10;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_mem_en", 32'(bus.mem_en), 32'd1);
        rst = 1'b1; bus.req = 1'b0;
        @(negedge clk);
        chk("abort_mem_en", 32'(bus.mem_en), 32'd0);
        chk("abort_ready", 32'(bus.ready), 32'd0);
        chk("abort_rdata", 32'(bus.rdata), 32'd0);
        chk("abort_error", 32'(bus.error), 32'd0);
        rst = 1'b0;
        exp_rdata = '0; exp_err = 1'b0; bv_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_ready", 32'(bus.ready), 32'd0);
        end

        // Random mix: reads/writes, out-of-range, repeats, back-to-back.
        for (int i = 0; i < 80; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 2) == 0) ? bus.addr : AW'($urandom_range(0, 255));
            xact(1'($urandom_range(0, 3) == 0), a, W'($urandom), 1'($urandom_range(0, 1)));
        end
        bus.req = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
